// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 16:1 mux path with a bounded hold time per grant.
// The one-cycle end-of-grant pulse is named release_pulse because `release` is a reserved word.
module rr_mux_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [3:0]  select,
    output logic [15:0] grant,
    output logic        grant_valid,
    output logic        release_pulse
);

    localparam logic [7:0] HOLD = 8'(HOLD_CYCLES);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [3:0]  select_nxt;
    logic [15:0] grant_nxt;
    logic        valid_nxt;
    logic        release_nxt;

    logic [3:0]  winner;
    logic [3:0]  idx;
    logic        found;

    // Rotating priority search: first requester at or after ptr, wrapping modulo 16.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        select_nxt  = select;
        grant_nxt   = grant;
        valid_nxt   = grant_valid;
        release_nxt = 1'b0;

        case (state)
            IDLE: begin
                grant_nxt = '0;
                valid_nxt = 1'b0;
                if (found) begin
                    state_nxt  = GRANT;
                    select_nxt = winner;
                    cnt_nxt    = 8'd1;
                    grant_nxt  = 16'd1 << winner;
                    valid_nxt  = 1'b1;
                end
            end
            GRANT: begin
                // Other requesters are ignored here; only the owner's request and the hold limit matter.
                if (req[select] && (cnt < HOLD)) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    state_nxt   = IDLE;
                    grant_nxt   = '0;
                    valid_nxt   = 1'b0;
                    release_nxt = 1'b1;
                    ptr_nxt     = select + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: state and outputs are updated with non-blocking assignments so every register samples pre-edge values.
    // NOTE: reset is asynchronous; it aborts an active grant immediately and suppresses the release pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            select        <= '0;
            grant         <= '0;
            grant_valid   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            cnt           <= cnt_nxt;
            select        <= select_nxt;
            grant         <= grant_nxt;
            grant_valid   <= valid_nxt;
            release_pulse <= release_nxt;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1,
// both checked every cycle against a grant-session model kept in plain integers.
module tb_rr_mux_arbiter;

    localparam int H_A = 4;
    localparam int H_B = 1;

    logic        clk;
    logic        reset;
    logic [15:0] req_a, req_b;
    logic [3:0]  sel_a, sel_b;
    logic [15:0] grant_a, grant_b;
    logic        valid_a, valid_b;
    logic        rel_a, rel_b;

    rr_mux_arbiter #(.HOLD_CYCLES(H_A)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .select(sel_a),
        .grant(grant_a), .grant_valid(valid_a), .release_pulse(rel_a)
    );

    rr_mux_arbiter #(.HOLD_CYCLES(H_B)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .select(sel_b),
        .grant(grant_b), .grant_valid(valid_b), .release_pulse(rel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct packed {
        logic        valid;
        logic [3:0]  sel;
        logic [15:0] grant;
        logic        rel;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Model: who owns the path (-1 = nobody), how long it has held it, where the next search starts.
    int m_ptr[2];
    int m_owner[2];
    int m_held[2];
    int m_last[2];

    function automatic void model_reset();
        for (int j = 0; j < 2; j++) begin
            m_ptr[j]   = 0;
            m_owner[j] = -1;
            m_held[j]  = 0;
            m_last[j]  = 0;
        end
    endfunction

    function automatic exp_t model_step(input int j, input logic [15:0] r);
        exp_t e;
        int   lim;
        int   w;
        lim   = (j == 0) ? H_A : H_B;
        e     = '0;
        e.sel = 4'(m_last[j]);
        if (m_owner[j] < 0) begin
            if (r != 16'h0000) begin
                for (int k = 0; k < 16; k++) begin
                    w = (m_ptr[j] + k) % 16;
                    if (m_owner[j] < 0 && r[w]) m_owner[j] = w;
                end
                m_held[j] = 1;
                m_last[j] = m_owner[j];
                e.valid   = 1'b1;
                e.sel     = 4'(m_owner[j]);
                e.grant   = 16'd1 << m_owner[j];
            end
        end else if (r[m_owner[j]] && m_held[j] < lim) begin
            m_held[j] = m_held[j] + 1;
            e.valid   = 1'b1;
            e.sel     = 4'(m_owner[j]);
            e.grant   = 16'd1 << m_owner[j];
        end else begin
            m_ptr[j]   = (m_owner[j] + 1) % 16;
            m_owner[j] = -1;
            e.rel      = 1'b1;
        end
        return e;
    endfunction

    // Stimulus side of the scoreboard: expected post-edge outputs are queued at every edge or reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
            q_a.delete();
            q_b.delete();
            q_a.push_back('0);
            q_b.push_back('0);
        end else begin
            q_a.push_back(model_step(0, req_a));
            q_b.push_back(model_step(1, req_b));
        end
    end

    task automatic compare_one(input string tag, input exp_t e, input logic v,
                               input logic [3:0] s, input logic [15:0] g, input logic r);
        check({tag, "_valid"},   32'(v), 32'(e.valid));
        check({tag, "_select"},  32'(s), 32'(e.sel));
        check({tag, "_grant"},   32'(g), 32'(e.grant));
        check({tag, "_release"}, 32'(r), 32'(e.rel));
        check({tag, "_inv_onehot"}, 32'(g), v ? 32'(16'd1 << s) : 32'd0);
        check({tag, "_inv_rel_vs_valid"}, 32'(r & v), 32'd0);
    endtask

    // Monitor: pops one expectation per instance each cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("a_queue_nonempty", 32'(q_a.size() != 0), 32'd1);
            check("b_queue_nonempty", 32'(q_b.size() != 0), 32'd1);
            if (q_a.size() != 0) compare_one("a", q_a.pop_front(), valid_a, sel_a, grant_a, rel_a);
            if (q_b.size() != 0) compare_one("b", q_b.pop_front(), valid_b, sel_b, grant_b, rel_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_a = '0;
        req_b = '0;
        reset = 1'b0;
        #2 reset = 1'b1;
        mon_en = 1'b1;
        ticks(2);
        reset = 1'b0;

        // Idle with no requests
        ticks(10);
        check("idle_valid", 32'(valid_a), 32'd0);
        check("idle_grant", 32'(grant_a), 32'd0);

        // Priority and wrap on the HOLD_CYCLES=4 instance
        req_a = 16'h8001;
        tick();
        check("wrap_first_sel", 32'(sel_a), 32'd0);
        check("wrap_first_valid", 32'(valid_a), 32'd1);
        ticks(3);
        check("wrap_hold4_sel", 32'(sel_a), 32'd0);
        tick();
        check("wrap_release0", 32'(rel_a), 32'd1);
        check("wrap_dead_valid", 32'(valid_a), 32'd0);
        tick();
        check("wrap_sel15", 32'(sel_a), 32'd15);
        ticks(3);
        check("wrap_sel15_held", 32'(grant_a), 32'h8000);
        tick();
        check("wrap_release15", 32'(rel_a), 32'd1);
        tick();
        check("wrap_back_to_0", 32'(sel_a), 32'd0);
        req_a = 16'h0000;
        ticks(3);

        // Early release when the owner drops its request
        req_a = 16'h0010;
        tick();
        check("early_grant1", 32'(grant_a), 32'h0010);
        tick();
        check("early_grant2", 32'(grant_a), 32'h0010);
        req_a = 16'h0000;
        tick();
        check("early_release", 32'(rel_a), 32'd1);
        check("early_grant_clear", 32'(grant_a), 32'd0);
        req_a = 16'hFFFF;
        tick();
        check("early_ptr_is_5", 32'(sel_a), 32'd5);
        req_a = 16'h0000;
        ticks(3);

        // Full load on the HOLD_CYCLES=1 instance
        req_b = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check("full_sel", 32'(sel_b), 32'(k % 16));
            check("full_valid", 32'(valid_b), 32'd1);
            tick();
            check("full_dead", 32'(valid_b), 32'd0);
            check("full_release", 32'(rel_b), 32'd1);
        end
        req_b = 16'h0000;
        ticks(3);

        // Asynchronous reset in the middle of a grant to requester 7
        req_a = 16'h0080;
        tick();
        check("mid_sel7", 32'(sel_a), 32'd7);
        tick();
        check("mid_sel7_held", 32'(valid_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_valid_clear", 32'(valid_a), 32'd0);
        check("async_grant_clear", 32'(grant_a), 32'd0);
        check("async_select_clear", 32'(sel_a), 32'd0);
        check("async_no_release", 32'(rel_a), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        req_a = 16'h8081;
        tick();
        check("post_reset_from_0", 32'(sel_a), 32'd0);
        check("post_reset_valid", 32'(valid_a), 32'd1);

        // Randomised traffic, with one asynchronous reset partway through
        for (int k = 0; k < 600; k++) begin
            tick();
            if (k == 300) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #3 reset = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req_a = 16'h0000;
                    1:       req_a = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    default: req_a = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req_b = 16'h0000;
                    1:       req_b = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    default: req_b = 16'($urandom);
                endcase
            end
        end

        req_a = 16'h0000;
        req_b = 16'h0000;
        ticks(4);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
